// File: rtl/dmem_responder.sv
// M-stage data-port responder: posted stores through a small write buffer,
// loads drain the buffer and then do a handshaked word read, stalling the pipe.
module dmem_responder #(
    parameter int WBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MaskM,
    input  logic        ReadEnM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [29:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_mask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(WBUF_DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [29:0]        rd_addr_q, rd_addr_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [29:0]        wbuf_addr_q [WBUF_DEPTH];
    logic [31:0]        wbuf_data_q [WBUF_DEPTH];
    logic [3:0]         wbuf_mask_q [WBUF_DEPTH];

    logic               push;
    logic               pop;
    logic               buf_empty;
    logic               buf_full;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^AddrM[1:0];
    assign buf_empty        = (occ_q == '0);
    assign buf_full         = (occ_q == OCC_W'(WBUF_DEPTH));
    assign ReadDataM        = rdata_q;

    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        rdata_d       = rdata_q;
        push          = 1'b0;
        pop           = 1'b0;
        StallM        = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_mask  = '0;

        // The buffer head is offered to memory whenever loads are not in progress.
        if ((state_q == S_IDLE || state_q == S_DRAIN) && !buf_empty) begin
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = wbuf_addr_q[rd_ptr_q];
            mem_req_wdata = wbuf_data_q[rd_ptr_q];
            mem_req_mask  = wbuf_mask_q[rd_ptr_q];
            pop           = mem_req_ready;
        end

        case (state_q)
            S_IDLE: begin
                if (ReadEnM) begin
                    StallM    = 1'b1;
                    rd_addr_d = AddrM[31:2];
                    state_d   = buf_empty ? S_RD_REQ : S_DRAIN;
                end else if (MaskM != 4'b0000) begin
                    // Stall is decided on current occupancy only, even if the head pops now.
                    if (buf_full) begin
                        StallM = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                StallM = 1'b1;
                if (buf_empty || (occ_q == OCC_W'(1) && pop)) begin
                    state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                StallM        = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_addr  = rd_addr_q;
                if (mem_req_ready) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                StallM = 1'b1;
                if (mem_resp_valid) begin
                    rdata_d = mem_resp_data;
                    state_d = S_RD_DONE;
                end
            end
            S_RD_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(WBUF_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(WBUF_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            rd_addr_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
        end
    end

    // Entry storage needs no reset: outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            wbuf_addr_q[wr_ptr_q] <= AddrM[31:2];
            wbuf_data_q[wr_ptr_q] <= WriteDataM;
            wbuf_mask_q[wr_ptr_q] <= MaskM;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a small backing-memory model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  MaskM;
    logic        ReadEnM;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [29:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'h0;

    int total = 0;
    int bad = 0;
    int n;

    logic [31:0] mem [0:255];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int wr_cnt_at_rd = 0;

    dmem_responder #(.WBUF_DEPTH(2)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .MaskM         (MaskM),
        .ReadEnM       (ReadEnM),
        .AddrM         (AddrM),
        .WriteDataM    (WriteDataM),
        .ReadDataM     (ReadDataM),
        .StallM        (StallM),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_mask  (mem_req_mask),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
    );

    always #5 clk = ~clk;

    // Backing memory: applies masked writes, answers reads one cycle after accept.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_resp_valid <= 1'b0;
            mem[8'h20]     <= 32'h12345678;
        end else begin
            mem_resp_valid <= 1'b0;
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_req_mask[b]) mem[mem_req_addr[7:0]][8*b +: 8] <= mem_req_wdata[8*b +: 8];
                    end
                    wr_cnt <= wr_cnt + 1;
                end else begin
                    mem_resp_valid <= 1'b1;
                    mem_resp_data  <= mem[mem_req_addr[7:0]];
                    rd_cnt         <= rd_cnt + 1;
                    wr_cnt_at_rd   <= wr_cnt;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] m, input logic ren, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MaskM      = m;
        ReadEnM    = ren;
        AddrM      = a;
        WriteDataM = d;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        MaskM = 4'h0; ReadEnM = 1'b0; AddrM = '0; WriteDataM = '0;
        mem_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'b0, StallM}, 32'h0);
        chk("rst_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("rst_rdata", ReadDataM, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single store
        mem_req_ready = 1'b1;
        step(4'hF, 1'b0, 32'h0000_0100, 32'hDEADBEEF);
        chk("st1_stall", {31'b0, StallM}, 32'h0);
        chk("st1_novalid", {31'b0, mem_req_valid}, 32'h0);
        step(4'h0, 1'b0, 32'h0, 32'h0);
        chk("st1_valid", {31'b0, mem_req_valid}, 32'h1);
        chk("st1_we", {31'b0, mem_req_we}, 32'h1);
        chk("st1_addr", {2'b0, mem_req_addr}, 32'h40);
        chk("st1_wdata", mem_req_wdata, 32'hDEADBEEF);
        chk("st1_mask", {28'b0, mem_req_mask}, 32'hF);
        step(4'h0, 1'b0, 32'h0, 32'h0);
        chk("st1_empty", {31'b0, mem_req_valid}, 32'h0);
        chk("st1_mem", mem[8'h40], 32'hDEADBEEF);

        // Byte store, held by ready low
        mem_req_ready = 1'b0;
        step(4'b0010, 1'b0, 32'h0000_0301, 32'h0000AB00);
        chk("bs_stall", {31'b0, StallM}, 32'h0);
        step(4'h0, 1'b0, 32'h0, 32'h0);
        chk("bs_valid", {31'b0, mem_req_valid}, 32'h1);
        chk("bs_addr", {2'b0, mem_req_addr}, 32'hC0);
        chk("bs_mask", {28'b0, mem_req_mask}, 32'h2);
        chk("bs_wdata", mem_req_wdata, 32'h0000AB00);
        step(4'h0, 1'b0, 32'h0, 32'h0);
        chk("bs_hold_valid", {31'b0, mem_req_valid}, 32'h1);
        chk("bs_hold_addr", {2'b0, mem_req_addr}, 32'hC0);
        mem_req_ready = 1'b1;
        step(4'h0, 1'b0, 32'h0, 32'h0);
        chk("bs_empty", {31'b0, mem_req_valid}, 32'h0);

        // Full buffer: third store stalls until a pop has been registered
        mem_req_ready = 1'b0;
        step(4'hF, 1'b0, 32'h0000_0010, 32'h11111111);
        chk("fb_s1_stall", {31'b0, StallM}, 32'h0);
        step(4'hF, 1'b0, 32'h0000_0014, 32'h22222222);
        chk("fb_s2_stall", {31'b0, StallM}, 32'h0);
        step(4'hF, 1'b0, 32'h0000_0018, 32'h33333333);
        chk("fb_s3_stall", {31'b0, StallM}, 32'h1);
        chk("fb_head_addr", {2'b0, mem_req_addr}, 32'h4);
        step(4'hF, 1'b0, 32'h0000_0018, 32'h33333333);
        mem_req_ready = 1'b1;
        chk("fb_popcycle_stall", {31'b0, StallM}, 32'h1);
        step(4'hF, 1'b0, 32'h0000_0018, 32'h33333333);
        chk("fb_s3_accept", {31'b0, StallM}, 32'h0);
        chk("fb_head2_addr", {2'b0, mem_req_addr}, 32'h5);
        step(4'h0, 1'b0, 32'h0, 32'h0);
        chk("fb_head3_addr", {2'b0, mem_req_addr}, 32'h6);
        chk("fb_head3_wdata", mem_req_wdata, 32'h33333333);
        step(4'h0, 1'b0, 32'h0, 32'h0);
        chk("fb_empty", {31'b0, mem_req_valid}, 32'h0);
        chk("fb_wr_cnt", wr_cnt, 32'd5);

        // Load latency with empty buffer and zero-wait memory
        step(4'h0, 1'b1, 32'h0000_0080, 32'h0);
        chk("ld_c0_stall", {31'b0, StallM}, 32'h1);
        chk("ld_c0_valid", {31'b0, mem_req_valid}, 32'h0);
        step(4'h0, 1'b1, 32'h0000_0080, 32'h0);
        chk("ld_c1_stall", {31'b0, StallM}, 32'h1);
        chk("ld_c1_valid", {31'b0, mem_req_valid}, 32'h1);
        chk("ld_c1_we", {31'b0, mem_req_we}, 32'h0);
        chk("ld_c1_addr", {2'b0, mem_req_addr}, 32'h20);
        chk("ld_c1_mask", {28'b0, mem_req_mask}, 32'h0);
        step(4'h0, 1'b1, 32'h0000_0080, 32'h0);
        chk("ld_c2_stall", {31'b0, StallM}, 32'h1);
        step(4'h0, 1'b1, 32'h0000_0080, 32'h0);
        chk("ld_c3_stall", {31'b0, StallM}, 32'h0);
        chk("ld_c3_rdata", ReadDataM, 32'h12345678);
        chk("ld_wr_before", wr_cnt_at_rd, 32'd5);
        step(4'h0, 1'b0, 32'h0, 32'h0);
        chk("ld_hold_rdata", ReadDataM, 32'h12345678);
        chk("ld_idle_stall", {31'b0, StallM}, 32'h0);

        // Store then load to the same address
        step(4'hF, 1'b0, 32'h0000_0200, 32'hCAFEF00D);
        chk("sl_st_stall", {31'b0, StallM}, 32'h0);
        step(4'h0, 1'b1, 32'h0000_0200, 32'h0);
        chk("sl_ld_stall", {31'b0, StallM}, 32'h1);
        chk("sl_drain_we", {31'b0, mem_req_we}, 32'h1);
        chk("sl_drain_addr", {2'b0, mem_req_addr}, 32'h80);
        n = 0;
        while (StallM && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("sl_no_timeout", {31'b0, (n < 20)}, 32'h1);
        chk("sl_rdata", ReadDataM, 32'hCAFEF00D);
        chk("sl_wr_before_rd", wr_cnt_at_rd, 32'd6);
        chk("sl_rd_cnt", rd_cnt, 32'd2);
        step(4'h0, 1'b0, 32'h0, 32'h0);

        // Reset mid-cycle with two buffered stores
        mem_req_ready = 1'b0;
        step(4'hF, 1'b0, 32'h0000_0400, 32'hAAAA0000);
        step(4'hF, 1'b0, 32'h0000_0404, 32'hBBBB0000);
        step(4'h0, 1'b0, 32'h0, 32'h0);
        chk("rm_pre_valid", {31'b0, mem_req_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("rm_we", {31'b0, mem_req_we}, 32'h0);
        chk("rm_addr", {2'b0, mem_req_addr}, 32'h0);
        chk("rm_wdata", mem_req_wdata, 32'h0);
        chk("rm_mask", {28'b0, mem_req_mask}, 32'h0);
        chk("rm_stall", {31'b0, StallM}, 32'h0);
        chk("rm_rdata", ReadDataM, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rm_no_write", wr_cnt, 32'd6);
        chk("rm_post_valid", {31'b0, mem_req_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipelined datapath's M-stage data port. It accepts one load or store per cycle from the datapath (byte mask, address, write data, load enable) and returns load data. Stores post into a small write buffer so they do not stall. Loads drain the buffer, then perform a handshaked word read on the backing-memory bus, stalling the pipeline with `StallM` until data is ready.

## Interface
Parameters:
- `WBUF_DEPTH`, 2, write-buffer entries; power of two, ≥1

Ports:
- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `MaskM`  in  4  byte write enables, pre-shifted by the datapath; nonzero = store
- `ReadEnM`  in  1  load request
- `AddrM`  in  32  byte address; bits [1:0] ignored
- `WriteDataM`  in  32  store data, pre-aligned
- `ReadDataM`  out  32  full loaded word; byte/half extraction is done by the datapath
- `StallM`  out  1  datapath must hold M-stage inputs stable while high
- `mem_req_valid`  out  1  backing-memory request valid
- `mem_req_ready`  in  1  request accepted when valid & ready
- `mem_req_we`  out  1  1 = write, 0 = read
- `mem_req_addr`  out  30  word address (`AddrM[31:2]`)
- `mem_req_wdata`  out  32  write data
- `mem_req_mask`  out  4  byte enables; 0000 for reads
- `mem_resp_valid`  in  1  one-cycle pulse carrying read data
- `mem_resp_data`  in  32  read data

## Operation
- **Write buffer:** a FIFO of {addr[31:2], data, mask}, `WBUF_DEPTH` deep, with an occupancy counter of width clog2(`WBUF_DEPTH`)+1.
- **States:** IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE.
- **IDLE, store** (`MaskM` != 0, `ReadEnM` = 0):
  - Not full: enqueue, `StallM` = 0.
  - Full: `StallM` = 1 and no enqueue.
  - `StallM` depends on occupancy only. A pop in the same cycle does not release a full stall; the store is accepted the next cycle.
- **IDLE, load** (`ReadEnM` = 1): `StallM` = 1 combinationally. Next state is DRAIN if the buffer is non-empty, else RD_REQ.
- **Load priority:** `ReadEnM` = 1 with `MaskM` != 0 is illegal and is treated as a load.
- **Draining:** in IDLE and DRAIN, when the buffer is non-empty, the FIFO head drives `mem_req_*` with `we` = 1. The head pops on valid & ready.
- **DRAIN:** go to RD_REQ when occupancy is 0 (after the final pop).
- **RD_REQ:**
  - `mem_req_valid` = 1, `we` = 0, `addr` = latched `AddrM[31:2]`, `mask` = 0000.
  - On ready, go to RD_WAIT.
- **RD_WAIT:** on `mem_resp_valid`, capture `mem_resp_data` into the read-data register and go to RD_DONE.
- **RD_DONE:**
  - `StallM` = 0 and `ReadDataM` = captured word; the load is consumed.
  - Go to IDLE unconditionally.
  - A new request is not evaluated until IDLE.
- **Ordering:** stores are never reordered, and a load always observes every earlier store, because the buffer drains before any read. No forwarding logic.
- **Stalled states:** `StallM` = 1 in DRAIN, RD_REQ and RD_WAIT.
- **Buffer during loads:** no enqueue occurs in DRAIN, RD_REQ, RD_WAIT or RD_DONE.
- **Reset values (async, `reset` low):**
  - state = IDLE, occupancy = 0, FIFO pointers = 0.
  - `ReadDataM` = 0, `StallM` = 0.
  - `mem_req_valid` = 0, `mem_req_we` = 0, `mem_req_addr` = 0, `mem_req_wdata` = 0, `mem_req_mask` = 0.
  - Reset mid-operation discards buffered stores and any in-flight read. `mem_resp_valid` is ignored outside RD_WAIT.

## Timing
- **`mem_req_*`:** driven only from state and FIFO registers; no combinational path from the datapath inputs. Once raised, `mem_req_valid` stays high, with payload stable, until ready.
- **`StallM`:** combinational from state, occupancy and `ReadEnM`/`MaskM`.
- **Store:** accepted in 0 stall cycles when the buffer is not full. The earliest memory write is the cycle after enqueue.
- **Load, empty buffer, zero-wait memory** (ready = 1, response in the cycle after the accept):
  - cycle 0: IDLE, stall
  - cycle 1: RD_REQ, accepted
  - cycle 2: RD_WAIT, response arrives
  - cycle 3: RD_DONE, `StallM` = 0
  - Result: 3 stall cycles. Each extra ready/response wait adds one cycle. Each buffered store adds ≥1 drain cycle.
- **`ReadDataM`:** holds its value until the next captured response.

## Test plan
- **Reset:** two stores buffered with `mem_req_ready` = 0, then pull `reset` low mid-cycle -> all outputs 0 immediately, occupancy 0, and no write is issued after release.
- **Single store:** store `AddrM` = 0x00000100, data 0xDEADBEEF, mask 1111, ready = 1 -> `StallM` 0. Next cycle: valid = 1, we = 1, addr = 0x40, wdata = 0xDEADBEEF, mask = 1111. The buffer is empty afterward.
- **Full buffer:** 3 back-to-back stores (depth 2) with ready = 0 -> the third sees `StallM` = 1. Raise ready -> the first write pops, and the third store is accepted the following cycle with `StallM` = 0.
- **Load latency:** load at 0x00000080, empty buffer, ready = 1, response 0x12345678 one cycle after the accept -> `StallM` high 3 cycles. Read request has addr = 0x20, mask = 0000. In RD_DONE, `ReadDataM` = 0x12345678 and `StallM` = 0.
- **Store-then-load ordering:** store 0xCAFEF00D to 0x200, then load 0x200 the next cycle -> the write handshake completes before the read request. The memory model returns 0xCAFEF00D to `ReadDataM`.
- **Byte store:** mask 0010, `AddrM` = 0x00000301, data 0x0000AB00 -> mem_req addr = 0xC0, mask = 0010, wdata = 0x0000AB00.
